// File: rtl/rr_arb_mux.sv
// rr_arb_mux: N-channel arbitrated data multiplexer with valid/ready on every
// input and a single registered output stage. Arbitration is round-robin
// (mode_i = 0) or explicit select (mode_i = 1). The output register reloads
// whenever it is empty or being drained, so back-to-back beats need no bubble.
//
// Optional build macro: ARB_LOCK_EN
//   Adds in_last_i. Once a non-final beat of a channel transfers, the grant
//   stays on that channel until its final beat transfers.
module rr_arb_mux #(
    parameter int DATA_W = 32,
    parameter int N_CH   = 10,
    parameter int SEL_W  = $clog2(N_CH)
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [N_CH*DATA_W-1:0]   in_data_i,
    input  logic [N_CH-1:0]          in_valid_i,
`ifdef ARB_LOCK_EN
    input  logic [N_CH-1:0]          in_last_i,
`endif
    output logic [N_CH-1:0]          in_ready_o,
    input  logic                     mode_i,
    input  logic [SEL_W-1:0]         sel_i,
    output logic [DATA_W-1:0]        out_data_o,
    output logic [SEL_W-1:0]         out_sel_o,
    output logic                     out_valid_o,
    input  logic                     out_ready_i,
    output logic                     sel_err_o
);

    // One extra bit so N_CH itself is representable even when N_CH = 2^SEL_W.
    localparam logic [SEL_W:0]   N_CH_W   = (SEL_W+1)'(N_CH);
    localparam logic [SEL_W-1:0] PTR_INIT = SEL_W'(N_CH - 1);

    logic [DATA_W-1:0] ch_data [N_CH];

    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic [SEL_W-1:0]  out_sel_q, out_sel_d;
    logic              out_valid_q, out_valid_d;
    logic              sel_err_q, sel_err_d;
    logic [SEL_W-1:0]  rr_ptr_q, rr_ptr_d;

    logic              load_en;
    logic              sel_oor;
    logic              grant_vld;
    logic [SEL_W-1:0]  grant_idx;
    logic              lock_held;
    int                cand;
    logic [SEL_W-1:0]  cand_idx;

`ifdef ARB_LOCK_EN
    logic              lock_q, lock_d;
    logic [SEL_W-1:0]  lock_ch_q, lock_ch_d;
    assign lock_held = lock_q;
`else
    assign lock_held = 1'b0;
`endif

    for (genvar k = 0; k < N_CH; k++) begin : g_split
        assign ch_data[k] = in_data_i[k*DATA_W +: DATA_W];
    end

    assign load_en = !out_valid_q || out_ready_i;
    assign sel_oor = ({1'b0, sel_i} >= N_CH_W);

    // Grant selection: lock (if enabled) beats fixed select beats round-robin.
    // The round-robin search wraps at N_CH, not at 2^SEL_W.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        cand      = 0;
        cand_idx  = '0;
`ifdef ARB_LOCK_EN
        if (lock_q) begin
            grant_vld = in_valid_i[lock_ch_q];
            grant_idx = lock_ch_q;
        end else
`endif
        if (mode_i) begin
            if (!sel_oor && in_valid_i[sel_i]) begin
                grant_vld = 1'b1;
                grant_idx = sel_i;
            end
        end else begin
            for (int k = 1; k <= N_CH; k++) begin
                cand = int'(rr_ptr_q) + k;
                if (cand >= N_CH) cand = cand - N_CH;
                cand_idx = SEL_W'(cand);
                if (!grant_vld && in_valid_i[cand_idx]) begin
                    grant_vld = 1'b1;
                    grant_idx = cand_idx;
                end
            end
        end
    end

    // Accept strobe: only the granted channel, and only when the stage can load.
    always_comb begin
        in_ready_o = '0;
        if (load_en && grant_vld) in_ready_o[grant_idx] = 1'b1;
    end

    // Next-state for the output stage, pointer, error flag and lock.
    always_comb begin
        out_data_d  = out_data_q;
        out_sel_d   = out_sel_q;
        out_valid_d = out_valid_q;
        rr_ptr_d    = rr_ptr_q;
        sel_err_d   = sel_err_q;
`ifdef ARB_LOCK_EN
        lock_d      = lock_q;
        lock_ch_d   = lock_ch_q;
`endif
        if (load_en) begin
            if (grant_vld) begin
                out_data_d  = ch_data[grant_idx];
                out_sel_d   = grant_idx;
                out_valid_d = 1'b1;
                rr_ptr_d    = grant_idx;
`ifdef ARB_LOCK_EN
                lock_d      = !in_last_i[grant_idx];
                lock_ch_d   = grant_idx;
`endif
            end else begin
                out_valid_d = 1'b0;
            end
        end
        if (mode_i && sel_oor && !lock_held) sel_err_d = 1'b1;
    end

    // State registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            out_data_q  <= '0;
            out_sel_q   <= '0;
            out_valid_q <= 1'b0;
            sel_err_q   <= 1'b0;
            rr_ptr_q    <= PTR_INIT;
`ifdef ARB_LOCK_EN
            lock_q      <= 1'b0;
            lock_ch_q   <= '0;
`endif
        end else begin
            out_data_q  <= out_data_d;
            out_sel_q   <= out_sel_d;
            out_valid_q <= out_valid_d;
            sel_err_q   <= sel_err_d;
            rr_ptr_q    <= rr_ptr_d;
`ifdef ARB_LOCK_EN
            lock_q      <= lock_d;
            lock_ch_q   <= lock_ch_d;
`endif
        end
    end

    assign out_data_o  = out_data_q;
    assign out_sel_o   = out_sel_q;
    assign out_valid_o = out_valid_q;
    assign sel_err_o   = sel_err_q;

endmodule

// File: tb/tb_rr_arb_mux.sv
// Testbench for rr_arb_mux (N_CH = 10, DATA_W = 32): directed vector table,
// hand sequences for stall and async reset, then randomized traffic against
// a behavioural model.
module tb_rr_arb_mux;

    localparam int N  = 10;
    localparam int DW = 32;
    localparam int SW = 4;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N*DW-1:0] in_data;
    logic [N-1:0]    in_valid = '0;
    logic [N-1:0]    in_ready;
    logic            mode = 1'b0;
    logic [SW-1:0]   sel = '0;
    logic [DW-1:0]   out_data;
    logic [SW-1:0]   out_sel;
    logic            out_valid;
    logic            out_ready = 1'b1;
    logic            sel_err;
`ifdef ARB_LOCK_EN
    logic [N-1:0]    in_last = '0;
`endif

    logic [DW-1:0] chd [N];

    int checks = 0;
    int errors = 0;
    bit chk_model = 1'b0;

    // Behavioural reference state
    bit            m_ov;
    logic [DW-1:0] m_data;
    logic [SW-1:0] m_sel;
    bit            m_err;
    int            m_ptr;
    bit            m_lock;
    int            m_lock_ch;

    typedef struct {
        logic [N-1:0]  valid;
        logic          mode;
        logic [SW-1:0] sel;
        logic          ordy;
        logic [N-1:0]  exp_rdy;
        logic          exp_ov;
        logic [SW-1:0] exp_osel;
        logic          exp_err;
    } vec_t;

    vec_t vecs[$];

    for (genvar k = 0; k < N; k++) begin : g_pack
        assign in_data[k*DW +: DW] = chd[k];
    end

    rr_arb_mux #(.DATA_W(DW), .N_CH(N)) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .in_data_i  (in_data),
        .in_valid_i (in_valid),
`ifdef ARB_LOCK_EN
        .in_last_i  (in_last),
`endif
        .in_ready_o (in_ready),
        .mode_i     (mode),
        .sel_i      (sel),
        .out_data_o (out_data),
        .out_sel_o  (out_sel),
        .out_valid_o(out_valid),
        .out_ready_i(out_ready),
        .sel_err_o  (sel_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [N-1:0] onehot(input int i);
        logic [N-1:0] one;
        one = {{(N-1){1'b0}}, 1'b1};
        return one << i;
    endfunction

    task automatic model_reset();
        m_ov = 0; m_data = '0; m_sel = '0; m_err = 0;
        m_ptr = N - 1; m_lock = 0; m_lock_ch = 0;
    endtask

    // Winner by the arbitration rules; -1 when nobody can be granted.
    function automatic int model_grant();
        int c;
        if (m_lock) return in_valid[m_lock_ch] ? m_lock_ch : -1;
        if (mode) return (int'(sel) < N && in_valid[sel]) ? int'(sel) : -1;
        for (int k = 1; k <= N; k++) begin
            c = (m_ptr + k) % N;
            if (in_valid[c]) return c;
        end
        return -1;
    endfunction

    // One clock: optional model checks before and after the rising edge.
    task automatic tick();
        int g;
        bit ld;
        logic [N-1:0] er;
        g  = model_grant();
        ld = !m_ov || out_ready;
        er = (ld && g >= 0) ? onehot(g) : '0;
        if (chk_model) chk("model_ready", in_ready, er);
        @(posedge clk);
        if (mode && int'(sel) >= N && !m_lock) m_err = 1;
        if (ld) begin
            if (g >= 0) begin
                m_ov = 1; m_data = chd[g]; m_sel = SW'(g); m_ptr = g;
`ifdef ARB_LOCK_EN
                m_lock = !in_last[g]; m_lock_ch = g;
`endif
            end else begin
                m_ov = 0;
            end
        end
        #1;
        if (chk_model) chk("model_out", {out_valid, out_data, out_sel, sel_err},
                           {m_ov, m_data, m_sel, m_err});
        @(negedge clk);
    endtask

    task automatic add(input logic [N-1:0] v, input logic md, input int s, input logic r,
                       input logic [N-1:0] er, input logic eov, input int es, input logic ee);
        vec_t t;
        t.valid = v; t.mode = md; t.sel = SW'(s); t.ordy = r;
        t.exp_rdy = er; t.exp_ov = eov; t.exp_osel = SW'(es); t.exp_err = ee;
        vecs.push_back(t);
    endtask

    initial begin
        for (int k = 0; k < N; k++) chd[k] = 32'hC0DE_0000 + k;
        chd[5] = 32'h1234_5678;

        // Round-robin over all channels from reset, then wrap back to 0
        for (int k = 0; k < N; k++) add('1, 0, 0, 1, onehot(k), 1, k, 0);
        add('1, 0, 0, 1, onehot(0), 1, 0, 0);
        // Only 3 and 7 valid: alternate, second round starts from rr_ptr = 7
        for (int r = 0; r < 4; r++) begin
            add(onehot(3) | onehot(7), 0, 0, 1, onehot(3), 1, 3, 0);
            add(onehot(3) | onehot(7), 0, 0, 1, onehot(7), 1, 7, 0);
        end
        // rr_ptr = 9 with only channel 0 valid wraps at N_CH
        add(onehot(9), 0, 0, 1, onehot(9), 1, 9, 0);
        add(onehot(0), 0, 0, 1, onehot(0), 1, 0, 0);
        // Fixed select, then out-of-range select (sticky error, no grant)
        add('1, 1, 5, 1, onehot(5), 1, 5, 0);
        add('1, 1, 12, 1, '0, 0, 5, 1);
        add('1, 0, 0, 1, onehot(6), 1, 6, 1);
        add('0, 0, 0, 1, '0, 0, 6, 1);

        model_reset();
        #2;
        chk("rst_valid", out_valid, 1'b0);
        chk("rst_data", out_data, 32'h0);
        chk("rst_sel", out_sel, 4'h0);
        chk("rst_err", sel_err, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        foreach (vecs[i]) begin
            in_valid = vecs[i].valid; mode = vecs[i].mode;
            sel = vecs[i].sel; out_ready = vecs[i].ordy;
            #1;
            chk($sformatf("vec%0d_ready", i), in_ready, vecs[i].exp_rdy);
            tick();
            chk($sformatf("vec%0d_out", i), {out_valid, out_sel, sel_err, out_data},
                {vecs[i].exp_ov, vecs[i].exp_osel, vecs[i].exp_err, chd[vecs[i].exp_osel]});
        end

        // Backpressure: hold DEADBEEF for three stalled cycles, then no bubble
        chd[3] = 32'hDEAD_BEEF;
        in_valid = onehot(3); mode = 0; out_ready = 1;
        tick();
        chk("bp_load", {out_valid, out_sel, out_data}, {1'b1, 4'd3, 32'hDEAD_BEEF});
        in_valid = '1; out_ready = 0;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk("bp_ready", in_ready, '0);
            tick();
            chk("bp_hold", {out_valid, out_sel, out_data}, {1'b1, 4'd3, 32'hDEAD_BEEF});
        end
        out_ready = 1;
        #1;
        chk("bp_release_ready", in_ready, onehot(4));
        tick();
        chk("bp_release_out", {out_valid, out_sel, out_data}, {1'b1, 4'd4, chd[4]});
        tick();
        chk("bp_next_out", {out_valid, out_sel, out_data}, {1'b1, 4'd5, chd[5]});

        // Async reset mid-stall with a held beat and sel_err set
        out_ready = 0;
        #2 rst = 1'b1;
        #1;
        chk("arst_out", {out_valid, out_sel, sel_err, out_data}, {1'b0, 4'd0, 1'b0, 32'h0});
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        in_valid = '1; out_ready = 1; mode = 0;
        #1;
        chk("arst_first_ready", in_ready, onehot(0));
        tick();
        chk("arst_first_out", {out_valid, out_sel}, {1'b1, 4'd0});

`ifdef ARB_LOCK_EN
        // Channel 2 sends a 3-beat packet while channel 4 waits
        in_valid = onehot(2) | onehot(4);
        for (int b = 0; b < 3; b++) begin
            in_last = (b == 2) ? onehot(2) : '0;
            #1;
            chk($sformatf("lock_beat%0d_ready", b), in_ready, onehot(2));
            tick();
            chk($sformatf("lock_beat%0d_sel", b), out_sel, 4'd2);
        end
        in_last = '0;
        #1;
        chk("lock_release_ready", in_ready, onehot(4));
        tick();
        chk("lock_release_sel", out_sel, 4'd4);
`endif

        // Randomized traffic against the model
        chk_model = 1'b1;
        for (int c = 0; c < 400; c++) begin
            for (int k = 0; k < N; k++) chd[k] = $urandom;
            in_valid  = N'($urandom);
            mode      = ($urandom_range(0, 3) == 0);
            sel       = ($urandom_range(0, 15) == 0) ? SW'($urandom_range(10, 15))
                                                     : SW'($urandom_range(0, 9));
            out_ready = ($urandom_range(0, 3) != 0);
`ifdef ARB_LOCK_EN
            in_last   = N'($urandom);
`endif
            #1;
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rr_arb_mux.md
Name: rr_arb_mux

Overview:
- Parametrised N-channel arbitrated data multiplexer with valid/ready handshakes on every input and on the output. Successor to the fixed 10:1 combinational word mux.
- Selects one requesting channel per cycle, either round-robin or by an explicit select, and registers the winner into a single output stage.
- Used where several datapath producers (writeback sources, load/store ports, peripherals) share one consumer and backpressure is required.

Parameters:
- DATA_W, 32, width of each data channel in bits.
- N_CH, 10, number of input channels (2..16).
- SEL_W, $clog2(N_CH), width of the select and granted-channel index.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  asynchronous reset, active-high.
- in_data_i  in  N_CH*DATA_W  channel k occupies bits [k*DATA_W +: DATA_W].
- in_valid_i  in  N_CH  per-channel request/valid.
- in_ready_o  out  N_CH  per-channel accept; at most one bit high per cycle.
- mode_i  in  1  0 = round-robin, 1 = fixed select.
- sel_i  in  SEL_W  channel index used when mode_i = 1.
- out_data_o  out  DATA_W  registered data.
- out_sel_o  out  SEL_W  index of the channel that produced out_data_o.
- out_valid_o  out  1  output holds a beat.
- out_ready_i  in  1  consumer accepts the beat.
- sel_err_o  out  1  sticky flag; set when mode_i = 1 and sel_i >= N_CH.

Behaviour:
- Reset (async assert, sync release): out_valid_o = 0, out_data_o = 0, out_sel_o = 0, sel_err_o = 0, rr_ptr = N_CH-1. With rr_ptr = N_CH-1, the first round-robin search starts at channel 0.
- load_en = !out_valid_o || out_ready_i. The output stage is full-throughput: one beat per cycle when the consumer is always ready.
- Grant is computed combinationally from in_valid_i, mode_i, sel_i and rr_ptr. in_ready_o[g] = load_en && granted(g); all other in_ready_o bits are 0.
- Round-robin (mode_i = 0): search channels rr_ptr+1, rr_ptr+2, ... wrapping modulo N_CH (not modulo 2^SEL_W). The first valid channel found is granted.
- Fixed (mode_i = 1): grant channel sel_i only if sel_i < N_CH and in_valid_i[sel_i] = 1.
  - If sel_i >= N_CH: no grant, and sel_err_o sets on that edge and stays high until reset.
- Transfer in when load_en is high and a grant exists. On the next edge:
  - out_data_o <= granted data;
  - out_sel_o <= granted index;
  - out_valid_o <= 1;
  - rr_ptr <= granted index (in both modes).
- When load_en is high and there is no grant: out_valid_o <= 0; out_data_o and out_sel_o hold their values.
- When load_en is low (stall): all registers hold and every in_ready_o bit is 0.
- Latency: a beat accepted at edge t is visible on out_data_o after edge t; input-to-output latency is 1 cycle.
- Simultaneous drain and refill in the same cycle is legal and is not a bubble.
- A change of mode_i or sel_i affects only the next arbitration; it never alters a beat already held in the output register.
- Reset asserted mid-stall: the held beat is discarded, and after release the first grant goes to channel 0 under round-robin.
- Input protocol: a producer must hold in_data_i and in_valid_i until it sees its in_ready_o high. The block does not check this rule.

Optional Feature:
- Macro: ARB_LOCK_EN.
- When defined:
  - Adds input port in_last_i [N_CH], which marks the final beat of a packet.
  - After a transfer with in_last_i[g] = 0, the grant locks to channel g, ignoring both mode_i and rr_ptr.
  - Only channel g may be granted until a beat with in_last_i[g] = 1 transfers; the lock then releases.
  - Reset clears the lock.
  - sel_err_o does not set while the lock is held.
- When undefined: no in_last_i port; every beat is arbitrated independently.

Test Plan:
- Round-robin, all channels valid, out_ready_i = 1, N_CH = 10: out_sel_o sequence 0,1,...,9,0; one beat per cycle; exactly one in_ready_o bit high each cycle.
- Round-robin, only channels 3 and 7 valid, rr_ptr = 7: grants alternate 3,7,3,7. Then with rr_ptr = 9 and only channel 0 valid, channel 0 is granted (wrap at N_CH, not 16).
- Backpressure: out_valid_o = 1, out_ready_i = 0 for 3 cycles. out_data_o = 0xDEADBEEF is held; in_ready_o = 0; on release the next beat follows with no bubble.
- Fixed mode: sel_i = 5 with channel 5 valid carrying 0x12345678 -> out_data_o = 0x12345678 and out_sel_o = 5. Then sel_i = 12 -> no grant, out_valid_o falls, sel_err_o = 1 and stays high.
- Async reset asserted mid-stream with out_valid_o = 1: outputs clear immediately. After release with all channels valid, the first out_sel_o = 0.
- ARB_LOCK_EN: channel 2 sends a 3-beat packet (last on beat 3) while channel 4 is valid. Beats 2,2,2 are granted, then 4. Channel 4 gets in_ready_o = 0 throughout the packet.
